// File: rtl/aes_avalon_master.sv
// Avalon-MM master sequencing one AES decryption: key/message writes, START, DONE polling,
// plaintext read-back. Optional DONE-poll timeout enabled by the AES_MASTER_TIMEOUT_EN macro.
module aes_avalon_master #(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         cmd_start,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_msg,
  output logic         cmd_busy,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         AVL_CS,
  output logic         AVL_READ,
  output logic         AVL_WRITE,
  output logic [3:0]   AVL_BYTE_EN,
  output logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_WRITEDATA,
  input  logic [31:0]  AVL_READDATA
);

  typedef enum logic [3:0] {
    StIdle, StWrKey, StWrMsg, StWrStart, StPollRd, StPollWait, StPollGap,
    StRdRes, StRdWait, StClrStart, StResp
  } state_e;

  localparam logic [7:0] LatLast = 8'(RD_LATENCY - 1);
  localparam logic [7:0] GapLast = 8'(POLL_GAP - 1);

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [127:0]   key_q, key_d, msg_q, msg_d, data_q, data_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [3:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

`ifdef AES_MASTER_TIMEOUT_EN
  localparam int unsigned PcW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PcW-1:0] PollMax  = PcW'(POLL_TIMEOUT);
  localparam logic [PcW-1:0] PollLast = PcW'(POLL_TIMEOUT - 1);
  logic [PcW-1:0] poll_q, poll_d;
  logic           err_q, err_d;
`endif

  // Lowest register address carries the most significant word.
  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] b);
    logic [31:0] w;
    case (b)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    key_d   = key_q;
    msg_d   = msg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef AES_MASTER_TIMEOUT_EN
    poll_d  = poll_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          key_d   = cmd_key;
          msg_d   = cmd_msg;
          beat_d  = 2'd0;
          data_d  = '0;
          addr_d  = 4'd0;
          wdata_d = cmd_key[127:96];
          state_d = StWrKey;
`ifdef AES_MASTER_TIMEOUT_EN
          poll_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StWrKey: begin
        if (beat_q == 2'd3) begin
          beat_d  = 2'd0;
          addr_d  = 4'd4;
          wdata_d = msg_q[127:96];
          state_d = StWrMsg;
        end else begin
          beat_d  = beat_q + 2'd1;
          addr_d  = {2'b00, beat_q + 2'd1};
          wdata_d = word_sel(key_q, beat_q + 2'd1);
        end
      end
      StWrMsg: begin
        if (beat_q == 2'd3) begin
          addr_d  = 4'd14;
          wdata_d = 32'h1;
          state_d = StWrStart;
        end else begin
          beat_d  = beat_q + 2'd1;
          addr_d  = {2'b01, beat_q + 2'd1};
          wdata_d = word_sel(msg_q, beat_q + 2'd1);
        end
      end
      StWrStart: begin
        addr_d  = 4'd15;
        state_d = StPollRd;
      end
      StPollRd: begin
        cnt_d   = '0;
        state_d = StPollWait;
      end
      StPollWait: begin
        if (cnt_q == LatLast) begin
          if (AVL_READDATA[0]) begin
            beat_d  = 2'd0;
            addr_d  = 4'd8;
            state_d = StRdRes;
          end else begin
            cnt_d   = '0;
            state_d = (POLL_GAP == 0) ? StPollRd : StPollGap;
`ifdef AES_MASTER_TIMEOUT_EN
            if (poll_q != PollMax) poll_d = poll_q + 1'b1;
            // This failed poll is number poll_q+1; give up once the budget is spent.
            if (poll_q >= PollLast) begin
              err_d   = 1'b1;
              data_d  = '0;
              addr_d  = 4'd14;
              wdata_d = 32'h0;
              state_d = StClrStart;
            end
`endif
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StPollGap: begin
        if (cnt_q == GapLast) state_d = StPollRd;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      StRdRes: begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == LatLast) begin
          case (beat_q)
            2'd0:    data_d[127:96] = AVL_READDATA;
            2'd1:    data_d[95:64]  = AVL_READDATA;
            2'd2:    data_d[63:32]  = AVL_READDATA;
            default: data_d[31:0]   = AVL_READDATA;
          endcase
          if (beat_q == 2'd3) begin
            addr_d  = 4'd14;
            wdata_d = 32'h0;
            state_d = StClrStart;
          end else begin
            beat_d  = beat_q + 2'd1;
            addr_d  = {2'b10, beat_q + 2'd1};
            state_d = StRdRes;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StClrStart: state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      beat_q  <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef AES_MASTER_TIMEOUT_EN
      poll_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef AES_MASTER_TIMEOUT_EN
      poll_q  <= poll_d;
      err_q   <= err_d;
`endif
    end
  end

  assign AVL_WRITE     = state_q inside {StWrKey, StWrMsg, StWrStart, StClrStart};
  assign AVL_READ      = state_q inside {StPollRd, StRdRes};
  assign AVL_CS        = AVL_READ | AVL_WRITE;
  assign AVL_BYTE_EN   = {4{AVL_CS}};
  assign AVL_ADDR      = addr_q;
  assign AVL_WRITEDATA = wdata_q;
  assign cmd_busy      = (state_q != StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign rsp_data      = data_q;

`ifdef AES_MASTER_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^POLL_TIMEOUT;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_avalon_master.sv
// Directed bench for aes_avalon_master: two instances (read latency 1 and 3) against a
// behavioural AES register slave that logs writes and answers reads after a fixed latency.
module tb_aes_avalon_master;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic         cmd_start [2];
  logic [127:0] cmd_key, cmd_msg;
  logic         cmd_busy [2], rsp_valid [2], rsp_err [2];
  logic [127:0] rsp_data [2];
  logic         avl_cs [2], avl_rd [2], avl_wr [2];
  logic [3:0]   avl_be [2], avl_addr [2];
  logic [31:0]  avl_wd [2], avl_rdata [2];

  aes_avalon_master #(.RD_LATENCY(1), .POLL_GAP(4), .POLL_TIMEOUT(1024)) dut (
    .CLK(CLK), .RESET(RESET), .cmd_start(cmd_start[0]), .cmd_key(cmd_key), .cmd_msg(cmd_msg),
    .cmd_busy(cmd_busy[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .AVL_CS(avl_cs[0]), .AVL_READ(avl_rd[0]), .AVL_WRITE(avl_wr[0]),
    .AVL_BYTE_EN(avl_be[0]), .AVL_ADDR(avl_addr[0]), .AVL_WRITEDATA(avl_wd[0]),
    .AVL_READDATA(avl_rdata[0])
  );

  aes_avalon_master #(.RD_LATENCY(3), .POLL_GAP(0), .POLL_TIMEOUT(8)) dut3 (
    .CLK(CLK), .RESET(RESET), .cmd_start(cmd_start[1]), .cmd_key(cmd_key), .cmd_msg(cmd_msg),
    .cmd_busy(cmd_busy[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .AVL_CS(avl_cs[1]), .AVL_READ(avl_rd[1]), .AVL_WRITE(avl_wr[1]),
    .AVL_BYTE_EN(avl_be[1]), .AVL_ADDR(avl_addr[1]), .AVL_WRITEDATA(avl_wd[1]),
    .AVL_READDATA(avl_rdata[1])
  );

  typedef struct {
    int          inst;
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] msg;
    logic [127:0] pt;
    int           da;
    int           lat;
    int           polls;
  } vec_t;

  // Slave model state
  int           cyc = 0;
  int           viol = 0;
  int           polls [2] = '{0, 0};
  int           rv_cnt [2] = '{0, 0};
  int           rv_cyc [2] = '{0, 0};
  logic [127:0] rv_data [2];
  logic         rv_err [2];
  int           done_after [2];
  logic [127:0] pt [2];
  logic [31:0]  garb [2] = '{32'h0, 32'h0};
  logic [31:0]  pd [2][4];
  logic         pv [2][4];
  wr_t          wlog [$];
  wr_t          cur [$];

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] word(input logic [127:0] v, input int b);
    return v[127-32*b -: 32];
  endfunction

  assign avl_rdata[0] = pv[0][0] ? pd[0][0] : garb[0];
  assign avl_rdata[1] = pv[1][2] ? pd[1][2] : garb[1];

  always @(negedge CLK) begin
    garb[0] <= $urandom;
    garb[1] <= $urandom;
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if ((avl_rd[i] && avl_wr[i]) || (avl_cs[i] != (avl_rd[i] | avl_wr[i])) ||
          (avl_be[i] != {4{avl_cs[i]}}))
        viol <= viol + 1;
      if (avl_wr[i]) begin
        wlog.push_back('{i, cyc, avl_addr[i], avl_wd[i]});
        if (avl_addr[i] == 4'd14 && avl_wd[i][0]) polls[i] <= 0;
      end
      for (int k = 1; k < 4; k++) begin
        pv[i][k] <= pv[i][k-1];
        pd[i][k] <= pd[i][k-1];
      end
      pv[i][0] <= avl_rd[i];
      if (avl_rd[i]) begin
        if (avl_addr[i] == 4'd15) begin
          polls[i] <= polls[i] + 1;
          pd[i][0] <= {garb[i][31:1], (polls[i] + 1 > done_after[i])};
        end else if (avl_addr[i][3:2] == 2'b10) begin
          pd[i][0] <= word(pt[i], int'(avl_addr[i][1:0]));
        end else begin
          pd[i][0] <= garb[i];
        end
      end
      if (rsp_valid[i]) begin
        rv_cnt[i]  <= rv_cnt[i] + 1;
        rv_cyc[i]  <= cyc;
        rv_data[i] <= rsp_data[i];
        rv_err[i]  <= rsp_err[i];
      end
    end
    if (RESET) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) pv[i][k] <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int i, input int prev, input int limit);
    int n = 0;
    while (rv_cnt[i] == prev && n < limit) begin
      @(negedge CLK);
      n++;
    end
    if (rv_cnt[i] == prev) begin
      n_chk++;
      n_err++;
      $display("FAIL rsp_timeout inst%0d: got no rsp_valid, expected one within %0d cycles",
               i, limit);
    end
  endtask

  // t0 is the cycle index the monitor sees at the accepting edge.
  task automatic start_txn(input int i, input logic [127:0] k, input logic [127:0] m,
                           output int t0);
    @(negedge CLK);
    cmd_key = k;
    cmd_msg = m;
    cmd_start[i] = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    cmd_start[i] = 1'b0;
  endtask

  task automatic collect(input int i, input int t_lo, input int t_hi);
    cur.delete();
    foreach (wlog[n])
      if (wlog[n].inst == i && wlog[n].cyc > t_lo && wlog[n].cyc <= t_hi) cur.push_back(wlog[n]);
  endtask

  task automatic check_writes(input string tag, input int i, input int t0,
                              input logic [127:0] k, input logic [127:0] m);
    logic [3:0]  ea;
    logic [31:0] ed;
    int          eo;
    collect(i, t0, rv_cyc[i]);
    chk({tag, "_nwr"}, 128'(cur.size()), 128'(10));
    for (int j = 0; j < 10; j++) begin
      if (j < 4)      begin ea = 4'(j);     ed = word(k, j);     eo = j + 1;               end
      else if (j < 8) begin ea = 4'(j);     ed = word(m, j - 4); eo = j + 1;               end
      else if (j == 8) begin ea = 4'd14;    ed = 32'h1;          eo = 9;                   end
      else             begin ea = 4'd14;    ed = 32'h0;          eo = rv_cyc[i] - t0 - 1;  end
      if (j < cur.size())
        chk($sformatf("%s_wr%0d", tag, j), {cur[j].addr, cur[j].data, 32'(cur[j].cyc - t0)},
            {ea, ed, 32'(eo)});
    end
  endtask

  initial begin
    vec_t        tv [3];
    logic [35:0] spec_wr [10];
    int          t0, prev, r1, n0, cr;
    logic        found;

    tv[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hdaec3055df058e1c39e814ea76f6747e,
              128'h33221100_77665544_bbaa9988_ffeeddcc, 20, 141, 21};
    tv[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8_885a308d_313198a2_e0370734, 0, 21, 1};
    tv[2] = '{128'hffffffff00000000a5a5a5a55a5a5a5a, 128'h0123456789abcdeffedcba9876543210,
              128'h00000001_80000000_deadbeef_cafef00d, 3, 39, 4};
    spec_wr = '{36'h0_00010203, 36'h1_04050607, 36'h2_08090a0b, 36'h3_0c0d0e0f,
                36'h4_daec3055, 36'h5_df058e1c, 36'h6_39e814ea, 36'h7_76f6747e,
                36'he_00000001, 36'he_00000000};

    RESET = 1'b1;
    cmd_start[0] = 1'b0;
    cmd_start[1] = 1'b0;
    cmd_key = '0;
    cmd_msg = '0;
    done_after[0] = 0;
    done_after[1] = 0;
    pt[0] = '0;
    pt[1] = '0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ctl%0d", i), {126'(0), cmd_busy[i], rsp_valid[i]}, 128'(0));
      chk($sformatf("rst_rsp%0d", i), rsp_data[i], 128'(0));
      chk($sformatf("rst_err%0d", i), 128'(rsp_err[i]), 128'(0));
      chk($sformatf("rst_bus%0d", i),
          128'({avl_cs[i], avl_rd[i], avl_wr[i], avl_be[i], avl_addr[i], avl_wd[i]}), 128'(0));
    end
    @(negedge CLK);
    RESET = 1'b0;

    for (int v = 0; v < 3; v++) begin
      pt[0] = tv[v].pt;
      done_after[0] = tv[v].da;
      wlog.delete();
      prev = rv_cnt[0];
      start_txn(0, tv[v].key, tv[v].msg, t0);
      wait_rsp(0, prev, 2000);
      chk($sformatf("v%0d_data", v), rv_data[0], tv[v].pt);
      chk($sformatf("v%0d_err", v), 128'(rv_err[0]), 128'(0));
      chk($sformatf("v%0d_latency", v), 128'(rv_cyc[0] - t0), 128'(tv[v].lat));
      chk($sformatf("v%0d_polls", v), 128'(polls[0]), 128'(tv[v].polls));
      check_writes($sformatf("v%0d", v), 0, t0, tv[v].key, tv[v].msg);
      if (v == 0)
        for (int j = 0; j < 10; j++)
          if (j < cur.size())
            chk($sformatf("spec_wr%0d", j), 128'({cur[j].addr, cur[j].data}), 128'(spec_wr[j]));
      repeat (3) @(negedge CLK);
      chk($sformatf("v%0d_hold", v), rsp_data[0], tv[v].pt);
      chk($sformatf("v%0d_pulse", v), {127'(0), rsp_valid[0]}, 128'(0));
    end

    // Latency 3 with garbage on the read bus outside the valid cycle.
    pt[1] = tv[2].pt;
    done_after[1] = 2;
    wlog.delete();
    prev = rv_cnt[1];
    start_txn(1, tv[2].key, tv[2].msg, t0);
    wait_rsp(1, prev, 2000);
    chk("lat3_data", rv_data[1], tv[2].pt);
    chk("lat3_latency", 128'(rv_cyc[1] - t0), 128'(39));
    chk("lat3_polls", 128'(polls[1]), 128'(3));
    check_writes("lat3", 1, t0, tv[2].key, tv[2].msg);

    // cmd_start held high: one transaction, next accepted the cycle after rsp_valid.
    pt[0] = tv[1].pt;
    done_after[0] = 0;
    wlog.delete();
    prev = rv_cnt[0];
    @(negedge CLK);
    cmd_key = tv[1].key;
    cmd_msg = tv[1].msg;
    t0 = cyc;
    cmd_start[0] = 1'b1;
    wait_rsp(0, prev, 500);
    r1 = rv_cyc[0];
    repeat (3) @(negedge CLK);
    cmd_start[0] = 1'b0;
    wait_rsp(0, prev + 1, 500);
    collect(0, t0, r1);
    n0 = 0;
    foreach (cur[n]) if (cur[n].addr == 4'd0) n0++;
    chk("held_one_txn", 128'(n0), 128'(1));
    collect(0, r1, r1 + 1000);
    if (cur.size() > 0) chk("held_2nd_start", {cur[0].addr, 32'(cur[0].cyc - r1)}, {4'd0, 32'd2});
    else                chk("held_2nd_start", 128'(cur.size()), 128'(1));
    chk("held_2nd_latency", 128'(rv_cyc[0] - r1), 128'(22));
    repeat (5) @(negedge CLK);
    chk("held_rsp_count", 128'(rv_cnt[0] - prev), 128'(2));

    // Reset while the message word at address 6 is on the bus.
    wlog.delete();
    prev = rv_cnt[0];
    start_txn(0, tv[2].key, tv[2].msg, t0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (avl_wr[0] && avl_addr[0] == 4'd6) found = 1'b1;
      else @(negedge CLK);
    end
    chk("rst_find_beat", 128'(found), 128'(1));
    cr = cyc;
    #1 RESET = 1'b1;
    #1;
    chk("abort_strobes", 128'({avl_cs[0], avl_rd[0], avl_wr[0], avl_be[0]}), 128'(0));
    chk("abort_busy", 128'(cmd_busy[0]), 128'(0));
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    collect(0, cr, cyc);
    chk("abort_no_bus", 128'(cur.size()), 128'(0));
    chk("abort_no_rsp", 128'(rv_cnt[0] - prev), 128'(0));
    chk("abort_rsp_data", rsp_data[0], 128'(0));
    pt[0] = tv[0].pt;
    done_after[0] = 0;
    wlog.delete();
    start_txn(0, tv[0].key, tv[0].msg, t0);
    wait_rsp(0, prev, 2000);
    chk("post_rst_data", rv_data[0], tv[0].pt);
    check_writes("post_rst", 0, t0, tv[0].key, tv[0].msg);

`ifdef AES_MASTER_TIMEOUT_EN
    done_after[1] = 100000;
    pt[1] = tv[0].pt;
    wlog.delete();
    prev = rv_cnt[1];
    start_txn(1, tv[0].key, tv[0].msg, t0);
    wait_rsp(1, prev, 2000);
    chk("to_err", 128'(rv_err[1]), 128'(1));
    chk("to_data", rv_data[1], 128'(0));
    chk("to_polls", 128'(polls[1]), 128'(8));
    collect(1, t0, rv_cyc[1]);
    chk("to_nwr", 128'(cur.size()), 128'(10));
    if (cur.size() > 0)
      chk("to_clr", {cur[cur.size()-1].addr, cur[cur.size()-1].data,
                     32'(rv_cyc[1] - cur[cur.size()-1].cyc)}, {4'd14, 32'h0, 32'd1});
`endif

    chk("bus_rules", 128'(viol), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
